ghash_mul_serial: RTL and testbench

GHASH_MUL_SERIAL -- requirements
Module: ghash_mul_serial

---
 rtl/ghash_mul_serial.sv | 176 +++++++++++++++++
 tb/tb_ghash_mul_serial.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ghash_mul_serial.sv
// ghash_mul_serial
// -----------------------------------------------------------------------------
// Bit-serial GF(2^128) multiplier for GHASH. It computes
//   z_out = (ac_in ^ blk_in) * h_in
// with one shift-and-add iteration per clock, 128 iterations per product.
// GCM bit order is used throughout: GCM bit i is vector bit [127-i], so the
// operand MSB x[127] is consumed first and V is shifted right each step.
//
// Timing: start accepted at edge N -> done pulses during cycle N+129, and the
// next start is accepted from cycle N+130. z_out changes only on the final
// iteration, so it never shows a partial sum.
//
// Ports
//   clk    : clock, rising edge
//   rst    : synchronous, active-high reset (clears control and datapath)
//   start  : request a new multiply, sampled only in IDLE
//   ac_in  : accumulator value (from the external ac_reg)
//   blk_in : next AAD / ciphertext block
//   h_in   : hash subkey H
//   abort  : cancel the multiply in progress (only with GHASH_MUL_ABORT_EN)
//   busy   : high while iterating
//   done   : one-cycle pulse when z_out holds a new product (drives ac_en)
//   z_out  : product register
//
// Build option
//   GHASH_MUL_ABORT_EN : adds the abort port. Abort in RUN returns to IDLE at
//                        the next edge with no done pulse and z_out unchanged.
//                        Abort is ignored in IDLE and DONE.
// -----------------------------------------------------------------------------
module ghash_mul_serial #(
  parameter int                 WIDTH = 128,
  parameter logic [WIDTH-1:0]   RPOLY = 128'hE100_0000_0000_0000_0000_0000_0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] ac_in,
  input  logic [WIDTH-1:0] blk_in,
  input  logic [WIDTH-1:0] h_in,
`ifdef GHASH_MUL_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] z_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] v_q;
  logic [WIDTH-1:0] z_q;
  logic [6:0]       cnt;

  logic             abort_req;
  logic             load;
  logic             iterate;
  logic             last_iter;
  logic [WIDTH-1:0] z_acc;

  // Multiply V by x in the reflected GCM representation: a right shift, and
  // when the x^127 coefficient (vector bit 0) falls off, fold it back with
  // the reduction constant.
  function automatic logic [WIDTH-1:0] v_step(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    r = v >> 1;
    if (v[0]) begin
      r = r ^ RPOLY;
    end
    return r;
  endfunction

  // Conditionally add V into Z depending on the current operand bit.
  function automatic logic [WIDTH-1:0] z_step(input logic [WIDTH-1:0] z,
                                              input logic [WIDTH-1:0] v,
                                              input logic             xbit);
    return xbit ? (z ^ v) : z;
  endfunction

`ifdef GHASH_MUL_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  assign load      = (state == IDLE) && start;
  assign iterate   = (state == RUN) && !abort_req;
  assign last_iter = iterate && (cnt == 7'd127);
  assign z_acc     = z_step(z_q, v_q, x_q[WIDTH-1]);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and outputs
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        // Abort takes priority over the final iteration as well.
        if (abort_req) begin
          state_nxt = IDLE;
        end else if (cnt == 7'd127) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Iteration counter; wraps to 0 on the last iteration.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 7'd0;
    end else if (load) begin
      cnt <= 7'd0;
    end else if (iterate) begin
      cnt <= cnt + 7'd1;
    end
  end

  // Operand / working registers. X is shifted left so its MSB is always the
  // bit being consumed; inputs are not resampled outside IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q <= '0;
      v_q <= '0;
      z_q <= '0;
    end else if (load) begin
      x_q <= ac_in ^ blk_in;
      v_q <= h_in;
      z_q <= '0;
    end else if (iterate) begin
      x_q <= x_q << 1;
      v_q <= v_step(v_q);
      z_q <= z_acc;
    end
  end

  // Result register: loaded only with the completed sum, held otherwise, so
  // an aborted multiply leaves the previous product visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      z_out <= '0;
    end else if (last_iter) begin
      z_out <= z_acc;
    end
  end

endmodule

// File: tb/tb_ghash_mul_serial.sv
// Testbench for ghash_mul_serial: scoreboard of expected products pushed at
// start and popped at the done pulse; GF(2^128) reference built from a
// plain polynomial multiply with x^128 = x^7 + x^2 + x + 1 reduction.
module tb_ghash_mul_serial;

  logic         clk;
  logic         rst;
  logic         start;
  logic [127:0] ac_in;
  logic [127:0] blk_in;
  logic [127:0] h_in;
`ifdef GHASH_MUL_ABORT_EN
  logic         abort;
`endif
  logic         busy;
  logic         done;
  logic [127:0] z_out;

  int           n_checks;
  int           n_fail;
  logic [127:0] exp_q[$];
  logic [127:0] prev_z;

  localparam logic [127:0] H1   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] C1   = 128'h0388dace60b6a392f328c2b971b2fe78;
  localparam logic [127:0] Z1   = 128'h5e2ec746917062882c85b0685353deb7;
  localparam logic [127:0] Z2   = 128'hf38cbb1ad69223dcc3457ae5b6b0f885;
  localparam logic [127:0] HONE = 128'h8000_0000_0000_0000_0000_0000_0000_0000;
  localparam logic [127:0] B3   = 128'h0123456789abcdeffedcba9876543210;

  ghash_mul_serial dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .ac_in  (ac_in),
    .blk_in (blk_in),
    .h_in   (h_in),
`ifdef GHASH_MUL_ABORT_EN
    .abort  (abort),
`endif
    .busy   (busy),
    .done   (done),
    .z_out  (z_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] gmul(input logic [127:0] x, input logic [127:0] h);
    logic [127:0] a;
    logic [127:0] b;
    logic [127:0] r;
    logic [254:0] p;
    logic [254:0] red;
    for (int i = 0; i < 128; i++) begin
      a[i] = x[127-i];
      b[i] = h[127-i];
    end
    p = '0;
    for (int i = 0; i < 128; i++) begin
      if (b[i]) p = p ^ ({127'b0, a} << i);
    end
    for (int i = 254; i >= 128; i--) begin
      if (p[i]) begin
        red  = 255'h87;
        p    = p ^ (red << (i - 128));
        p[i] = 1'b0;
      end
    end
    for (int j = 0; j < 128; j++) r[127-j] = p[j];
    return r;
  endfunction

  // mode 0: plain; 1: extra start pulses at N+5 and N+128; 2: rst at N+60;
  // 3: abort at N+40. Called at #1 after a rising edge.
  task automatic run_op(input logic [127:0] ac, input logic [127:0] blk,
                        input logic [127:0] h, input int mode);
    int           ndone;
    int           k_done;
    logic [127:0] e;
    ndone  = 0;
    k_done = 0;
    ac_in  = ac;
    blk_in = blk;
    h_in   = h;
    start  = 1'b1;
    if (mode < 2) exp_q.push_back(gmul(ac ^ blk, h));
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      if (mode == 1 && (k == 5 || k == 128)) begin
        start  = 1'b1;
        ac_in  = ~ac;
        blk_in = blk ^ 128'h1234;
        h_in   = ~h;
      end
      if (mode == 2 && k == 60) rst = 1'b1;
`ifdef GHASH_MUL_ABORT_EN
      if (mode == 3 && k == 40) abort = 1'b1;
`endif
      @(posedge clk);
      #1;
      start = 1'b0;
      rst   = 1'b0;
`ifdef GHASH_MUL_ABORT_EN
      abort = 1'b0;
`endif
      if (mode == 2 && k == 60) begin
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_z", z_out, 0);
        prev_z = '0;
        return;
      end
      if (mode == 3 && k == 40) begin
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_z", z_out, prev_z);
        for (int j = 0; j < 140; j++) begin
          @(posedge clk);
          #1;
          if (done) ndone++;
        end
        chk("abort_no_done", ndone, 0);
        chk("abort_z_hold", z_out, prev_z);
        return;
      end
      if (k == 64) chk("no_partial", z_out, prev_z);
      if (k == 64) chk("busy_run", busy, 1);
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          k_done = k;
          chk("latency", k, 128);
          chk("busy_done", busy, 0);
          e = exp_q.pop_front();
          chk("z_out", z_out, e);
          prev_z = e;
        end
      end
      if (ndone > 0 && k >= k_done + 3) break;
    end
    chk("done_pulses", ndone, 1);
    if (ndone == 0 && exp_q.size() > 0) void'(exp_q.pop_front());
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    prev_z   = '0;
    rst      = 1'b1;
    start    = 1'b0;
    ac_in    = '0;
    blk_in   = '0;
    h_in     = '0;
`ifdef GHASH_MUL_ABORT_EN
    abort    = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_z", z_out, 0);
    rst = 1'b0;

    // Start in the very first cycle after reset release.
    run_op('0, C1, H1, 0);
    chk("vec1_const", z_out, Z1);
    run_op(Z1, 128'h80, H1, 0);
    chk("vec2_const", z_out, Z2);
    run_op('0, B3, HONE, 0);
    chk("unity", z_out, B3);

    // Extra start pulses while busy must not disturb the product.
    run_op('0, C1, H1, 1);
    chk("restart_ignored", z_out, Z1);

    // Reset mid-run, then a start two cycles later.
    run_op(Z1, 128'h80, H1, 2);
    @(posedge clk);
    #1;
    run_op('0, C1, H1, 0);
    chk("after_rst", z_out, Z1);

    // Zero operands.
    run_op(B3, B3, H1, 0);
    run_op(C1, '0, '0, 0);

    // Random operands.
    for (int i = 0; i < 4; i++) begin
      run_op({$urandom, $urandom, $urandom, $urandom},
             {$urandom, $urandom, $urandom, $urandom},
             {$urandom, $urandom, $urandom, $urandom}, 0);
    end

`ifdef GHASH_MUL_ABORT_EN
    run_op(Z1, 128'h80, H1, 3);
    @(posedge clk);
    #1;
    run_op(Z1, 128'h80, H1, 0);
    chk("after_abort", z_out, Z2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
